// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Groups the instruction-memory request/response channel, the branch redirect
// inputs and the decode-side valid/ready channel of the fetch unit.
//
// Signals:
//   mem_ce     fetch request / chip enable to instruction memory
//   mem_addr   word-aligned byte address of the requested instruction
//   mem_inst   instruction word returned by memory
//   mem_valid  memory response valid (transfer on mem_ce & mem_valid)
//   br_flag    one-cycle redirect pulse
//   br_target  redirect address (low two bits ignored)
//   id_valid   fetch buffer head valid
//   id_ready   decode accepts the head entry
//   id_pc      PC of the head entry
//   id_inst    instruction of the head entry
//
// Modports:
//   master  the fetch unit
//   slave   the environment (memory, branch unit, decode stage)
// ---------------------------------------------------------------------------
interface inst_fetch_if;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        mem_valid;
    logic        br_flag;
    logic [31:0] br_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output mem_ce, mem_addr, id_valid, id_pc, id_inst,
        input  mem_inst, mem_valid, br_flag, br_target, id_ready
    );

    modport slave (
        input  mem_ce, mem_addr, id_valid, id_pc, id_inst,
        output mem_inst, mem_valid, br_flag, br_target, id_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch initiator. Generates the PC, issues word requests to
// instruction memory, captures returned words into a small {pc, inst} buffer
// and presents the buffer head to decode through a valid/ready handshake.
// Branch redirects flush the buffer and drop any response still in flight.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  fetch buffer entries (power of 2, >= 2)
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   inst_fetch_if.master (memory, branch and decode channels)
//   perf_fetch_cnt / perf_discard_cnt (only with FETCH_PERF_CNT_EN defined):
//         count of words pushed into the buffer / responses dropped
//
// Optional feature macro: FETCH_PERF_CNT_EN
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_discard_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               mem_ce_q, mem_ce_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        buf_pc_q   [FIFO_DEPTH];
    logic [31:0]        buf_inst_q [FIFO_DEPTH];

    logic               xfer_s;
    logic               pop_s;
    logic               push_s;
    logic               flush_s;
    logic               room_after_push_s;
    logic [CNT_W-1:0]   count_after_push_s;
    logic [31:0]        br_pc_s;

    assign xfer_s  = mem_ce_q & bus.mem_valid;
    assign pop_s   = (count_q != {CNT_W{1'b0}}) & bus.id_ready;
    assign br_pc_s = {bus.br_target[31:2], 2'b00};

    // Occupancy after this edge's push, used to decide whether to keep requesting.
    assign count_after_push_s = count_q + {{(CNT_W-1){1'b0}}, 1'b1}
                                        - {{(CNT_W-1){1'b0}}, pop_s};
    assign room_after_push_s  = (count_after_push_s < CNT_W'(FIFO_DEPTH));

    // Next-state logic: branch redirect has priority over push and pop.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_ce_d   = mem_ce_q;
        mem_addr_d = mem_addr_q;
        push_s     = 1'b0;
        flush_s    = 1'b0;

        if (bus.br_flag) begin
            flush_s = 1'b1;
            pc_d    = br_pc_s;
            case (state_q)
                S_FETCH, S_DISCARD: begin
                    if (xfer_s) begin
                        // The completing word belongs to the old stream: drop it.
                        state_d    = S_FETCH;
                        mem_ce_d   = 1'b1;
                        mem_addr_d = br_pc_s;
                    end else begin
                        // Request cannot be withdrawn; wait for it and drop it.
                        state_d = S_DISCARD;
                    end
                end
                S_HOLD, S_IDLE: begin
                    state_d    = S_FETCH;
                    mem_ce_d   = 1'b1;
                    mem_addr_d = br_pc_s;
                end
                default: begin
                    state_d  = S_IDLE;
                    mem_ce_d = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_FETCH;
                    mem_ce_d   = 1'b1;
                    mem_addr_d = pc_q;
                end
                S_FETCH: begin
                    if (xfer_s) begin
                        push_s = 1'b1;
                        pc_d   = pc_q + 32'd4;
                        if (room_after_push_s) begin
                            mem_ce_d   = 1'b1;
                            mem_addr_d = pc_q + 32'd4;
                        end else begin
                            mem_ce_d = 1'b0;
                            state_d  = S_HOLD;
                        end
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (pop_s) begin
                        state_d    = S_FETCH;
                        mem_ce_d   = 1'b1;
                        mem_addr_d = pc_q;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DISCARD: begin
                    if (xfer_s) begin
                        state_d    = S_FETCH;
                        mem_ce_d   = 1'b1;
                        mem_addr_d = pc_q;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    mem_ce_d = 1'b0;
                end
            endcase
        end
    end

    // Buffer pointer and occupancy update; a flush overrides push and pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_s) begin
            count_d  = {CNT_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
        end else begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, push_s}
                              - {{(CNT_W-1){1'b0}}, pop_s};
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // FSM state, request outputs and fetch buffer storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_ce_q   <= 1'b0;
            mem_addr_q <= 32'h0000_0000;
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_q[i]   <= 32'h0000_0000;
                buf_inst_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_ce_q   <= mem_ce_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push_s) begin
                buf_pc_q[wr_ptr_q]   <= mem_addr_q;
                buf_inst_q[wr_ptr_q] <= bus.mem_inst;
            end else begin
                buf_pc_q[wr_ptr_q]   <= buf_pc_q[wr_ptr_q];
                buf_inst_q[wr_ptr_q] <= buf_inst_q[wr_ptr_q];
            end
        end
    end

    // Decode sees only registered state, so a push shows up one cycle later.
    assign bus.mem_ce   = mem_ce_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.id_valid = (count_q != {CNT_W{1'b0}});
    assign bus.id_pc    = buf_pc_q[rd_ptr_q];
    assign bus.id_inst  = buf_inst_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_discard_q;
    logic        drop_s;

    // A completion is dropped when it belongs to a stream already redirected.
    assign drop_s = xfer_s & (bus.br_flag | (state_q == S_DISCARD));

    // Wrapping counters of pushed words and dropped responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q   <= 32'h0000_0000;
            perf_discard_q <= 32'h0000_0000;
        end else begin
            if (push_s) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end else begin
                perf_fetch_q <= perf_fetch_q;
            end
            if (drop_s) begin
                perf_discard_q <= perf_discard_q + 32'd1;
            end else begin
                perf_discard_q <= perf_discard_q;
            end
        end
    end

    assign perf_fetch_cnt   = perf_fetch_q;
    assign perf_discard_cnt = perf_discard_q;
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Initiator side of the instruction-memory fetch interface: generates the PC, drives chip-enable and address to instruction memory, and captures returned instruction words.
- Buffers {pc, inst} pairs in a small FIFO feeding the decode stage through a valid/ready handshake.
- Handles branch redirects by flushing the buffer and discarding any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mem_ce  out  1  fetch request / chip enable to instruction memory
- mem_addr  out  32  byte address of the requested word, bits [1:0] always 0
- mem_inst  in  32  returned instruction word
- mem_valid  in  1  memory response valid; a transfer completes on a rising edge with mem_ce=1 and mem_valid=1
- br_flag  in  1  redirect request, one-cycle pulse
- br_target  in  32  redirect address
- id_valid  out  1  buffer head valid
- id_ready  in  1  decode accepts the head entry
- id_pc  out  32  PC of the head entry
- id_inst  out  32  instruction of the head entry

Behaviour:
- Reset (async, any time, including mid-transfer):
  - mem_ce=0, mem_addr=0, id_valid=0, id_pc=0, id_inst=0.
  - FIFO empty, pc=RESET_PC, state=S_IDLE.
- States:
  - S_IDLE: one cycle after reset release, then S_FETCH.
  - S_FETCH: transfer in progress.
  - S_HOLD: buffer full, no request outstanding.
  - S_DISCARD: in-flight response is to be dropped.
- Request rule:
  - A new request may start only when FIFO count < FIFO_DEPTH.
  - On start: mem_ce=1, mem_addr=pc.
  - mem_ce and mem_addr stay stable until completion; a request is never withdrawn except by reset.
- Memory latency:
  - Any latency is allowed, including 0 (mem_valid tied high gives one word per cycle).
- S_FETCH on completion:
  - Push {mem_addr, mem_inst}; pc <= pc + 4 (wraps modulo 2^32).
  - If the FIFO still has room after push and pop this edge, issue the next request immediately (mem_ce stays 1, mem_addr = new pc); otherwise mem_ce=0 and go to S_HOLD.
- S_HOLD: on a pop, return to S_FETCH next cycle.
- Overflow is impossible by construction: a request only starts with a free slot, and the count only decreases while waiting.
- Decode side:
  - id_valid = FIFO non-empty; id_pc/id_inst = head entry.
  - Pop on id_valid && id_ready.
  - Head outputs stay stable while id_valid=1 and id_ready=0.
  - Push into an empty FIFO is visible on id_valid the next cycle (no combinational memory-to-decode path).
- Push and pop on the same edge: both take effect; count unchanged.
- br_flag=1 (highest priority, overrides push and pop):
  - FIFO cleared; id_valid=0 from the next cycle.
  - pc <= {br_target[31:2], 2'b00}.
  - If a transfer is pending and not completing this edge: go to S_DISCARD, holding mem_ce/mem_addr.
  - If a transfer completes this same edge: drop the data and go to S_FETCH at the new pc.
  - From S_HOLD or S_IDLE: go to S_FETCH at the new pc.
- S_DISCARD:
  - On completion, drop the data (no push) and go to S_FETCH at the current pc.
  - A further br_flag here updates pc only and stays in S_DISCARD.
- Branch target with bits [1:0] != 0: low bits silently cleared.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt (32) and perf_discard_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on every pushed word.
  - perf_discard_cnt increments on every dropped completion (S_DISCARD completion, or completion coinciding with br_flag).
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Zero-latency stream: mem_valid=1, id_ready=1, RESET_PC=0 -> id_pc sequence 0x0, 0x4, 0x8, ... one per cycle after startup; mem_addr never skips or repeats.
- Backpressure: id_ready=0 for 10 cycles, mem_valid=1 -> exactly 2 words buffered (pc 0x0, 0x4); mem_ce=0 in S_HOLD; after id_ready=1, words delivered in order with no loss.
- Latency 3: mem_valid high every third cycle -> mem_addr held constant across each wait; id_pc advances by 4 per completion.
- Branch during pending transfer: br_flag with br_target=0x100 while request 0x8 outstanding -> 0x8 response dropped; next request addr=0x100; first delivered id_pc=0x100; perf_discard_cnt=1 when FETCH_PERF_CNT_EN is defined.
- Branch coinciding with completion and pop, br_target=0x203 -> no push; FIFO empty next cycle; next mem_addr=0x200.
- Async reset asserted mid-S_FETCH -> mem_ce, id_valid, mem_addr, id_pc, id_inst go 0 without waiting for a clock edge; after release, first request addr=RESET_PC.
